// File: rtl/riscv_defines.sv
// Shared RISC-V definitions: CSR op encodings, widths and the CSR request payload.
package riscv_defines;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_OP_W   = 2;

    localparam logic [CSR_OP_W-1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [CSR_OP_W-1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [CSR_OP_W-1:0] CSR_OP_SET   = 2'b10;
    localparam logic [CSR_OP_W-1:0] CSR_OP_CLEAR = 2'b11;

    // One access as presented to the CSR file
    typedef struct packed {
        logic [CSR_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
        logic [CSR_OP_W-1:0]   op;
    } csr_req_t;

endpackage

// File: rtl/riscv_csr_arbiter.sv
// Arbitrates a single CSR file port between the core and the debug module.
// The core normally wins; debug wins when the core is idle or after debug has
// lost MAX_DBG_WAIT consecutive cycles. Debug responses are held until consumed.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   core_req_i/addr/wdata/op        core CSR request
//   core_gnt_o                      core access performed this cycle (comb)
//   core_rvalid_o, core_rdata_o     core read response, one cycle after grant
//   dbg_req_i/addr/wdata/we         debug CSR request
//   dbg_gnt_o                       debug access performed this cycle (comb)
//   dbg_rvalid_o, dbg_rdata_o       held debug response
//   dbg_rready_i                    debug consumes response
//   csr_access_o/addr/wdata/op      CSR file access (comb)
//   csr_rdata_i                     combinational CSR read data
module riscv_csr_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned MAX_DBG_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  core_req_i,
    input  logic [CSR_ADDR_W-1:0] core_addr_i,
    input  logic [XLEN-1:0]       core_wdata_i,
    input  logic [CSR_OP_W-1:0]   core_op_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [XLEN-1:0]       core_rdata_o,

    input  logic                  dbg_req_i,
    input  logic [CSR_ADDR_W-1:0] dbg_addr_i,
    input  logic [XLEN-1:0]       dbg_wdata_i,
    input  logic                  dbg_we_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [XLEN-1:0]       dbg_rdata_o,
    input  logic                  dbg_rready_i,

    output logic                  csr_access_o,
    output logic [CSR_ADDR_W-1:0] csr_addr_o,
    output logic [XLEN-1:0]       csr_wdata_o,
    output logic [CSR_OP_W-1:0]   csr_op_o,
    input  logic [XLEN-1:0]       csr_rdata_i
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_DBG_WAIT);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_DBG_RSP = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;

    logic             w_dbg_elig;
    logic             w_dbg_gnt;
    logic             w_core_gnt;
    csr_req_t         w_csr_req;

    logic             r_core_rvalid;
    logic [XLEN-1:0]  r_core_rdata;
    logic [XLEN-1:0]  r_dbg_rdata;

    // Grant decision: debug only when eligible and core idle or debug starved
    always_comb begin
        w_dbg_elig = 1'b0;
        w_dbg_gnt  = 1'b0;
        w_core_gnt = 1'b0;
        w_dbg_elig = dbg_req_i && (r_state == ST_IDLE);
        w_dbg_gnt  = w_dbg_elig && (!core_req_i || (r_wait_cnt == WAIT_MAX));
        w_core_gnt = core_req_i && !w_dbg_gnt;
    end

    // CSR port mux; with no grant the core fields pass through with op NONE
    always_comb begin
        w_csr_req = '{addr: core_addr_i, wdata: core_wdata_i, op: CSR_OP_NONE};
        if (w_dbg_gnt) begin
            w_csr_req.addr  = dbg_addr_i;
            w_csr_req.wdata = dbg_wdata_i;
            w_csr_req.op    = dbg_we_i ? CSR_OP_WRITE : CSR_OP_NONE;
        end else if (w_core_gnt) begin
            w_csr_req.op    = core_op_i;
        end
    end

    assign core_gnt_o    = w_core_gnt;
    assign dbg_gnt_o     = w_dbg_gnt;
    assign csr_access_o  = w_core_gnt || w_dbg_gnt;
    assign csr_addr_o    = w_csr_req.addr;
    assign csr_wdata_o   = w_csr_req.wdata;
    assign csr_op_o      = w_csr_req.op;

    assign core_rvalid_o = r_core_rvalid;
    assign core_rdata_o  = r_core_rdata;
    assign dbg_rvalid_o  = (r_state == ST_DBG_RSP);
    assign dbg_rdata_o   = r_dbg_rdata;

    // Next state and starvation counter (counter holds while a response is pending)
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_IDLE:    if (w_dbg_gnt)    w_state_nxt = ST_DBG_RSP;
            ST_DBG_RSP: if (dbg_rready_i) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
        if (w_dbg_gnt) begin
            w_wait_cnt_nxt = '0;
        end else if (w_dbg_elig && (r_wait_cnt < WAIT_MAX)) begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Response registers; debug data captures pre-write CSR value on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rdata   <= '0;
        end else begin
            r_core_rvalid <= w_core_gnt;
            if (w_core_gnt) r_core_rdata <= csr_rdata_i;
            if (w_dbg_gnt)  r_dbg_rdata  <= csr_rdata_i;
        end
    end

endmodule

// File: tb/tb_riscv_csr_arbiter.sv
// Randomized and directed bench for riscv_csr_arbiter against a behavioural model.
module tb_riscv_csr_arbiter;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i;
    logic [11:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [1:0]  core_op_i;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        dbg_req_i;
    logic [11:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_we_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_rready_i;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;

    riscv_csr_arbiter #(.MAX_DBG_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_op_i(core_op_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_we_i(dbg_we_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o(dbg_rdata_o), .dbg_rready_i(dbg_rready_i),
        .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_op_o(csr_op_o), .csr_rdata_i(csr_rdata_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: pending debug response, how long debug has been losing,
    // and the last core response.
    bit          m_pend;
    logic [31:0] m_pend_data;
    int          m_losses;
    bit          m_core_rvalid;
    logic [31:0] m_core_rdata;

    // Values observed in the most recent cycle, for directed literal checks
    logic        obs_core_gnt, obs_dbg_gnt, obs_dbg_rvalid, obs_core_rvalid;
    logic [1:0]  obs_op;
    logic [31:0] obs_dbg_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend        = 1'b0;
        m_pend_data   = '0;
        m_losses      = 0;
        m_core_rvalid = 1'b0;
        m_core_rdata  = '0;
    endtask

    // Compare every output against the model for the current inputs, then
    // advance the model across the clock edge.
    task automatic check_and_step();
        bit          elig, dg, cg;
        logic [1:0]  e_op;
        elig = dbg_req_i && !m_pend;
        dg   = elig && (!core_req_i || m_losses >= int'(MAXW));
        cg   = core_req_i && !dg;
        e_op = dg ? (dbg_we_i ? 2'b01 : 2'b00) : (cg ? core_op_i : 2'b00);

        chk("core_gnt",    32'(core_gnt_o),    32'(cg));
        chk("dbg_gnt",     32'(dbg_gnt_o),     32'(dg));
        chk("csr_access",  32'(csr_access_o),  32'(dg | cg));
        chk("csr_addr",    32'(csr_addr_o),    32'(dg ? dbg_addr_i : core_addr_i));
        chk("csr_wdata",   csr_wdata_o,        dg ? dbg_wdata_i : core_wdata_i);
        chk("csr_op",      32'(csr_op_o),      32'(e_op));
        chk("core_rvalid", 32'(core_rvalid_o), 32'(m_core_rvalid));
        chk("core_rdata",  core_rdata_o,       m_core_rdata);
        chk("dbg_rvalid",  32'(dbg_rvalid_o),  32'(m_pend));
        chk("dbg_rdata",   dbg_rdata_o,        m_pend_data);

        obs_core_gnt    = core_gnt_o;
        obs_dbg_gnt     = dbg_gnt_o;
        obs_op          = csr_op_o;
        obs_dbg_rvalid  = dbg_rvalid_o;
        obs_core_rvalid = core_rvalid_o;
        obs_dbg_rdata   = dbg_rdata_o;

        @(posedge clk);
        if (m_pend && dbg_rready_i) m_pend = 1'b0;
        if (dg) begin
            m_pend      = 1'b1;
            m_pend_data = csr_rdata_i;
            m_losses    = 0;
        end else if (elig && m_losses < int'(MAXW)) begin
            m_losses++;
        end
        m_core_rvalid = cg;
        if (cg) m_core_rdata = csr_rdata_i;
        @(negedge clk);
    endtask

    // Drive one cycle of inputs (called at negedge), then check and step.
    task automatic cycle(input bit creq, input logic [11:0] caddr, input logic [31:0] cwd,
                         input logic [1:0] cop, input bit dreq, input logic [11:0] daddr,
                         input logic [31:0] dwd, input bit dwe, input bit rrdy,
                         input logic [31:0] rdata);
        core_req_i   = creq;  core_addr_i = caddr; core_wdata_i = cwd; core_op_i = cop;
        dbg_req_i    = dreq;  dbg_addr_i  = daddr; dbg_wdata_i  = dwd; dbg_we_i  = dwe;
        dbg_rready_i = rrdy;  csr_rdata_i = rdata;
        #1;
        check_and_step();
    endtask

    task automatic idle_inputs();
        core_req_i = 0; core_addr_i = '0; core_wdata_i = '0; core_op_i = 2'b00;
        dbg_req_i  = 0; dbg_addr_i  = '0; dbg_wdata_i  = '0; dbg_we_i  = 0;
        dbg_rready_i = 0; csr_rdata_i = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; released at the next negedge.
    task automatic mid_cycle_reset();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dbg_rvalid",  32'(dbg_rvalid_o),  32'd0);
        chk("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("rst_dbg_rdata",   dbg_rdata_o,        32'd0);
        chk("rst_csr_access",  32'(csr_access_o),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("por_core_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("por_dbg_rvalid",  32'(dbg_rvalid_o),  32'd0);
        chk("por_core_rdata",  core_rdata_o,       32'd0);
        chk("por_dbg_rdata",   dbg_rdata_o,        32'd0);
        chk("por_csr_op",      32'(csr_op_o),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Core-only SET stream: granted every cycle, rvalid trails by one
        for (int i = 0; i < 10; i++) begin
            cycle(1, 12'h300, 32'(i), 2'b10, 0, '0, '0, 0, 0, 32'h1000 + 32'(i));
            chk("stream_gnt", 32'(obs_core_gnt), 32'd1);
            chk("stream_op",  32'(obs_op),       32'd2);
            if (i > 0) chk("stream_rvalid", 32'(obs_core_rvalid), 32'd1);
        end

        // Debug read with idle core; response held until rready
        cycle(0, '0, '0, 2'b00, 1, 12'h341, '0, 0, 0, 32'hDEAD0004);
        chk("dread_gnt", 32'(obs_dbg_gnt), 32'd1);
        chk("dread_op",  32'(obs_op),      32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, '0, 2'b00, 0, '0, '0, 0, 0, 32'h0BAD0BAD);
            chk("dread_hold_v", 32'(obs_dbg_rvalid), 32'd1);
            chk("dread_hold_d", obs_dbg_rdata,       32'hDEAD0004);
        end
        cycle(0, '0, '0, 2'b00, 0, '0, '0, 0, 1, '0);
        cycle(0, '0, '0, 2'b00, 0, '0, '0, 0, 0, '0);
        chk("dread_released", 32'(obs_dbg_rvalid), 32'd0);

        // Starvation: core continuous, debug wins on the fifth cycle
        for (int i = 0; i < 7; i++) begin
            cycle(1, 12'h305, 32'h5, 2'b01, (i <= 4), 12'h7B0, 32'h77, 0, 0, 32'h40 + 32'(i));
            chk("starve_core", 32'(obs_core_gnt), (i == 4) ? 32'd0 : 32'd1);
            chk("starve_dbg",  32'(obs_dbg_gnt),  (i == 4) ? 32'd1 : 32'd0);
        end

        // Pending response blocks a second debug request; core unaffected
        for (int i = 0; i < 6; i++) begin
            cycle(1, 12'h300, '0, 2'b00, 1, 12'h7B1, '0, 0, 0, 32'h99);
            chk("pend_no_dbg", 32'(obs_dbg_gnt),  32'd0);
            chk("pend_core",   32'(obs_core_gnt), 32'd1);
        end
        cycle(1, 12'h300, '0, 2'b00, 1, 12'h7B1, '0, 0, 1, 32'h99);
        chk("pend_rrdy_no_dbg", 32'(obs_dbg_gnt), 32'd0);
        cycle(0, '0, '0, 2'b00, 1, 12'h7B1, '0, 0, 0, 32'hABCD);
        chk("pend_next_gnt", 32'(obs_dbg_gnt), 32'd1);

        // Reset while in DBG_RSP drops the response
        mid_cycle_reset();

        // Three losses, then reset: counter must restart from zero
        for (int i = 0; i < 3; i++) cycle(1, 12'h1, '0, 2'b00, 1, 12'h2, '0, 0, 0, '0);
        mid_cycle_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 12'h1, '0, 2'b00, 1, 12'h2, '0, 0, 0, '0);
            chk("rst_cnt_dbg", 32'(obs_dbg_gnt), (i == 4) ? 32'd1 : 32'd0);
        end
        cycle(0, '0, '0, 2'b00, 0, '0, '0, 0, 1, '0);

        // Debug write after reset: op WRITE, response carries pre-write value
        cycle(0, '0, '0, 2'b00, 1, 12'h300, 32'h1, 1, 0, 32'h0000_1800);
        chk("dwrite_op",  32'(obs_op),      32'd1);
        chk("dwrite_gnt", 32'(obs_dbg_gnt), 32'd1);
        cycle(0, '0, '0, 2'b00, 0, '0, '0, 0, 1, '0);
        chk("dwrite_rsp", obs_dbg_rdata, 32'h0000_1800);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), 12'($urandom), $urandom, 2'($urandom),
                  ($urandom_range(0, 1) == 1), 12'($urandom), $urandom, 1'($urandom),
                  ($urandom_range(0, 9) < 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
